// File: rtl/sad3_block_reduce.sv
// ---------------------------------------------------------------------------
// sad3_block_reduce
//
// SAD3-stage block reducer. Each accepted beat carries four per-row absolute
// difference partial sums (A2..D2). ROWS beats are accumulated into one block
// SAD, which is handed to writeback over a valid/ready handshake. Across a
// motion search the smallest block SAD and its block index are tracked.
//
// Ports
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous reset, active-high
//   InValid    in   1      A2..D2 / InRegDst valid this cycle
//   InReady    out  1      stage can accept a beat (ACCUM state, not in reset)
//   A2..D2     in   32     unsigned partial absolute differences
//   InRegDst   in   5      destination register, sampled on a block's last beat
//   InClear    in   1      start a new search (clear min tracking / block index)
//   OutValid   out  1      block result valid
//   OutReady   in   1      writeback consumes the result
//   OutSAD     out  ACC_W  SAD of the completed block
//   OutIdx     out  IDX_W  index of the completed block
//   OutRegDst  out  5      destination register for OutSAD
//   MinSAD     out  ACC_W  smallest block SAD since the last clear
//   MinIdx     out  IDX_W  index of MinSAD
//
// Configuration macro
//   SAD_SATURATE_EN  defined  : accumulation clamps at 2^ACC_W-1
//                    undefined: accumulation wraps modulo 2^ACC_W
//
// ACC_W is expected to be at least 32 (the input width).
// ---------------------------------------------------------------------------
module sad3_block_reduce #(
  parameter int ROWS  = 4,
  parameter int ACC_W = 32,
  parameter int IDX_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      A2,
  input  logic [31:0]      B2,
  input  logic [31:0]      C2,
  input  logic [31:0]      D2,
  input  logic [4:0]       InRegDst,
  input  logic             InClear,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [ACC_W-1:0] OutSAD,
  output logic [IDX_W-1:0] OutIdx,
  output logic [4:0]       OutRegDst,
  output logic [ACC_W-1:0] MinSAD,
  output logic [IDX_W-1:0] MinIdx
);

  // Beat sum needs ACC_W+3 bits; one more bit holds acc + beat sum.
  localparam int SUM_W  = ACC_W + 3;
  localparam int WIDE_W = SUM_W + 1;

  // Row counter is 8 bits: ROWS is at most 256, so the last row index fits.
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Adds one beat to the accumulator. Saturating build clamps on overflow,
  // which also keeps a saturated accumulator pinned at all-ones until the
  // block ends (every beat is non-negative).
  function automatic logic [ACC_W-1:0] add_beat(
    input logic [ACC_W-1:0] acc,
    input logic [31:0]      a,
    input logic [31:0]      b,
    input logic [31:0]      c,
    input logic [31:0]      d
  );
`ifdef SAD_SATURATE_EN
    logic [SUM_W-1:0]  beat;
    logic [WIDE_W-1:0] wide;
    beat = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
    wide = WIDE_W'(acc) + WIDE_W'(beat);
    if (|wide[WIDE_W-1:ACC_W]) begin
      add_beat = {ACC_W{1'b1}};
    end else begin
      add_beat = wide[ACC_W-1:0];
    end
`else
    // Only the low ACC_W bits survive wrapping, so sum directly at ACC_W.
    add_beat = acc + ACC_W'(a) + ACC_W'(b) + ACC_W'(c) + ACC_W'(d);
`endif
  endfunction

  state_t           state_r,      state_n_s;
  logic [ACC_W-1:0] acc_r,        acc_n_s;
  logic [7:0]       row_cnt_r,    row_cnt_n_s;
  logic [IDX_W-1:0] blk_idx_r,    blk_idx_n_s;
  logic             min_seen_r,   min_seen_n_s;
  logic             clr_pend_r,   clr_pend_n_s;
  logic             out_valid_r,  out_valid_n_s;
  logic [ACC_W-1:0] out_sad_r,    out_sad_n_s;
  logic [IDX_W-1:0] out_idx_r,    out_idx_n_s;
  logic [4:0]       out_regdst_r, out_regdst_n_s;
  logic [ACC_W-1:0] min_sad_r,    min_sad_n_s;
  logic [IDX_W-1:0] min_idx_r,    min_idx_n_s;

  logic             in_ready_s;
  logic             accept_s;
  logic [ACC_W-1:0] acc_base_s;
  logic [7:0]       row_base_s;
  logic [IDX_W-1:0] idx_base_s;
  logic             seen_base_s;
  logic [ACC_W-1:0] min_sad_base_s;
  logic [IDX_W-1:0] min_idx_base_s;
  logic [ACC_W-1:0] next_s;

  // Next-state and datapath: handshake, clear, accumulate, min tracking, handoff.
  always_comb begin
    state_n_s      = state_r;
    acc_n_s        = acc_r;
    row_cnt_n_s    = row_cnt_r;
    blk_idx_n_s    = blk_idx_r;
    min_seen_n_s   = min_seen_r;
    clr_pend_n_s   = clr_pend_r;
    out_valid_n_s  = out_valid_r;
    out_sad_n_s    = out_sad_r;
    out_idx_n_s    = out_idx_r;
    out_regdst_n_s = out_regdst_r;
    min_sad_n_s    = min_sad_r;
    min_idx_n_s    = min_idx_r;

    in_ready_s = (state_r == ST_ACCUM) & ~Reset;
    accept_s   = InValid & in_ready_s;

    // A clear in ACCUM takes effect before a same-cycle beat, so the beat
    // sees a fresh search: row 0 of block 0 with no minimum recorded.
    if (InClear) begin
      acc_base_s     = {ACC_W{1'b0}};
      row_base_s     = 8'd0;
      idx_base_s     = {IDX_W{1'b0}};
      seen_base_s    = 1'b0;
      min_sad_base_s = {ACC_W{1'b0}};
      min_idx_base_s = {IDX_W{1'b0}};
    end else begin
      acc_base_s     = acc_r;
      row_base_s     = row_cnt_r;
      idx_base_s     = blk_idx_r;
      seen_base_s    = min_seen_r;
      min_sad_base_s = min_sad_r;
      min_idx_base_s = min_idx_r;
    end

    next_s = add_beat(acc_base_s, A2, B2, C2, D2);

    case (state_r)
      ST_ACCUM: begin
        acc_n_s      = acc_base_s;
        row_cnt_n_s  = row_base_s;
        blk_idx_n_s  = idx_base_s;
        min_seen_n_s = seen_base_s;
        min_sad_n_s  = min_sad_base_s;
        min_idx_n_s  = min_idx_base_s;
        if (accept_s) begin
          if (row_base_s == LAST_ROW) begin
            out_sad_n_s    = next_s;
            out_idx_n_s    = idx_base_s;
            out_regdst_n_s = InRegDst;
            out_valid_n_s  = 1'b1;
            state_n_s      = ST_HOLD;
            min_seen_n_s   = 1'b1;
            // Strict less-than: on a tie the earlier block index is kept.
            if (!seen_base_s || (next_s < min_sad_base_s)) begin
              min_sad_n_s = next_s;
              min_idx_n_s = idx_base_s;
            end else begin
              min_sad_n_s = min_sad_base_s;
              min_idx_n_s = min_idx_base_s;
            end
          end else begin
            acc_n_s     = next_s;
            row_cnt_n_s = row_base_s + 8'd1;
          end
        end else begin
          state_n_s = ST_ACCUM;
        end
      end

      ST_HOLD: begin
        // The pending result is untouched by a clear; only min tracking is
        // wiped now, and the block index restart is deferred to the handoff.
        if (InClear) begin
          min_seen_n_s = 1'b0;
          min_sad_n_s  = {ACC_W{1'b0}};
          min_idx_n_s  = {IDX_W{1'b0}};
          clr_pend_n_s = 1'b1;
        end else begin
          clr_pend_n_s = clr_pend_r;
        end
        if (OutReady) begin
          out_valid_n_s = 1'b0;
          acc_n_s       = {ACC_W{1'b0}};
          row_cnt_n_s   = 8'd0;
          clr_pend_n_s  = 1'b0;
          state_n_s     = ST_ACCUM;
          if (InClear || clr_pend_r) begin
            blk_idx_n_s = {IDX_W{1'b0}};
          end else begin
            blk_idx_n_s = blk_idx_r + IDX_W'(1);
          end
        end else begin
          state_n_s = ST_HOLD;
        end
      end

      default: begin
        state_n_s     = ST_ACCUM;
        out_valid_n_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ST_ACCUM;
      acc_r        <= {ACC_W{1'b0}};
      row_cnt_r    <= 8'd0;
      blk_idx_r    <= {IDX_W{1'b0}};
      min_seen_r   <= 1'b0;
      clr_pend_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_sad_r    <= {ACC_W{1'b0}};
      out_idx_r    <= {IDX_W{1'b0}};
      out_regdst_r <= 5'd0;
      min_sad_r    <= {ACC_W{1'b0}};
      min_idx_r    <= {IDX_W{1'b0}};
    end else begin
      state_r      <= state_n_s;
      acc_r        <= acc_n_s;
      row_cnt_r    <= row_cnt_n_s;
      blk_idx_r    <= blk_idx_n_s;
      min_seen_r   <= min_seen_n_s;
      clr_pend_r   <= clr_pend_n_s;
      out_valid_r  <= out_valid_n_s;
      out_sad_r    <= out_sad_n_s;
      out_idx_r    <= out_idx_n_s;
      out_regdst_r <= out_regdst_n_s;
      min_sad_r    <= min_sad_n_s;
      min_idx_r    <= min_idx_n_s;
    end
  end

  assign InReady   = in_ready_s;
  assign OutValid  = out_valid_r;
  assign OutSAD    = out_sad_r;
  assign OutIdx    = out_idx_r;
  assign OutRegDst = out_regdst_r;
  assign MinSAD    = min_sad_r;
  assign MinIdx    = min_idx_r;

endmodule
